seg_scan_driver: RTL

//  Reader side of the digit bus written by the clock/stopwatch top level.

---
 rtl/seg_scan_driver.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/seg_scan_driver.sv
// Eight-digit multiplexed seven-segment scanner with per-frame input shadowing.
// Optional digit blinking is compiled in when SEG_BLINK_EN is defined.
module seg_scan_driver #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int BLINK_HZ = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] digits,
  input  logic [7:0]  disp_en,
  input  logic [7:0]  dp,
`ifdef SEG_BLINK_EN
  input  logic [7:0]  blink_mask,
`endif
  output logic [7:0]  seg_en,
  output logic [7:0]  seg_out,
  output logic        frame_start
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] DIV_M1 = PW'(DIV - 1);

  if (DIV < 4 || BLINK_HZ < 1) begin : g_bad_cfg
    $error("seg_scan_driver: DIV must be >= 4 and BLINK_HZ >= 1");
  end

  logic [PW-1:0] cnt;
  logic [2:0]    idx;
  logic          load_pend;
  logic [31:0]   sh_d;
  logic [7:0]    sh_en;
  logic [7:0]    sh_dp;
  logic          tick;
  logic          load;
  logic          hide;
  logic [3:0]    cur_d;
  logic [7:0]    nxt_en;
  logic [7:0]    nxt_out;

  assign tick = (cnt == DIV_M1);
  assign load = (tick && idx == 3'd7) || load_pend;

  function automatic logic [6:0] dec(input logic [3:0] c);
    logic [6:0] s;
    unique case (c)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
    endcase
    return s;
  endfunction

`ifdef SEG_BLINK_EN
  localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int BW   = $clog2(HALF + 1);
  localparam logic [BW-1:0] HALF_M1 = BW'(HALF - 1);

  logic [BW-1:0] bcnt;
  logic          phase;
  logic [7:0]    sh_blink;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt     <= '0;
      phase    <= 1'b0;
      sh_blink <= '0;
    end else begin
      if (bcnt == HALF_M1) begin
        bcnt  <= '0;
        phase <= ~phase;
      end else begin
        bcnt <= bcnt + 1'b1;
      end
      if (load) sh_blink <= blink_mask;
    end
  end

  assign hide = phase & sh_blink[idx];
`else
  assign hide = 1'b0;
`endif

  always_comb begin
    cur_d   = sh_d[{idx, 2'b00} +: 4];
    nxt_en  = 8'h00;
    nxt_out = 8'h00;
    if (sh_en[idx] && !hide) begin
      nxt_en  = 8'b1 << idx;
      nxt_out = {sh_dp[idx], dec(cur_d)};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      idx         <= '0;
      load_pend   <= 1'b1;
      sh_d        <= '0;
      sh_en       <= '0;
      sh_dp       <= '0;
      seg_en      <= '0;
      seg_out     <= '0;
      frame_start <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) idx <= idx + 3'd1;
      if (load) begin
        sh_d      <= digits;
        sh_en     <= disp_en;
        sh_dp     <= dp;
        load_pend <= 1'b0;
      end
      frame_start <= load;
      // blank one cycle at each digit change so the previous pattern never ghosts
      if (tick) begin
        seg_en  <= '0;
        seg_out <= '0;
      end else begin
        seg_en  <= nxt_en;
        seg_out <= nxt_out;
      end
    end
  end

endmodule
